// File: rtl/_pipe_r.sv
// Elastic pipeline register: DEPTH valid/ready stages with a synchronous flush.
// Bubbles collapse under backpressure; ready ripples from the output back to stage 0.
module _pipe_r #(
  parameter int unsigned  n       = 8,
  parameter int unsigned  DEPTH   = 2,
  parameter logic [n-1:0] RST_VAL = {n{1'b0}},
  localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [n-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [n-1:0]  out_data,
  output logic [CW-1:0] count
);

  if (DEPTH == 0) begin : g_depth_check
    $error("_pipe_r: DEPTH must be at least 1");
  end

  // Handshake: a word moves across a boundary on a rising edge where valid && ready;
  // valid never waits on ready, and a stalled output holds its word and valid unchanged.
  logic [DEPTH-1:0] v_q, v_d;
  logic [n-1:0]     d_q [DEPTH];
  logic [n-1:0]     d_d [DEPTH];
  logic [DEPTH-1:0] r;
  logic             in_hs;

  // Stage i can take a word if any stage from i to the output is empty, or the output drains.
  always_comb begin
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v_q[j]) r[i] = 1'b1;
      end
    end
  end

  assign in_ready = r[0] && !flush && rst_n;
  assign in_hs    = in_valid && in_ready;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) d_d[i] = RST_VAL;
    end else begin
      if (r[0]) begin
        v_d[0] = in_hs;
        if (in_hs) d_d[0] = in_data;
      end
      // Data only follows a valid word, so bubbles leave the old contents in place.
      for (int i = 1; i < DEPTH; i++) begin
        if (r[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) count = count + CW'(v_q[i]);
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb__pipe_r.sv
// Bench for _pipe_r: a DEPTH=3 and a DEPTH=1 instance under directed and random traffic,
// compared every cycle against a slot-level model plus hand-computed expectations.
module tb__pipe_r;

  localparam int         DA  = 3;
  localparam int         DB  = 1;
  localparam logic [7:0] RVA = 8'h00;
  localparam logic [7:0] RVB = 8'hFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a;
  logic [7:0] in_data_a, out_data_a;
  logic [1:0] count_a;
  logic       flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [7:0] in_data_b, out_data_b;
  logic [0:0] count_b;

  _pipe_r #(.n(8), .DEPTH(DA), .RST_VAL(RVA)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush_a),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .count(count_a)
  );

  _pipe_r #(.n(8), .DEPTH(DB), .RST_VAL(RVB)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .count(count_b)
  );

  // Model: a row of slots; each cycle the output slot drains if taken, words step
  // forward into empty slots (output side first), and an accepted word enters slot 0.
  typedef struct packed {
    logic [3:0]      v;
    logic [3:0][7:0] d;
  } mdl_t;

  mdl_t       m_a, m_b;
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] bp_exp [4];
  int         n_checks = 0;
  int         n_err    = 0;
  logic       rnd_or_a = 1'b0;

  function automatic mdl_t mdl_clear(input logic [7:0] rv);
    mdl_t s;
    s.v = '0;
    for (int i = 0; i < 4; i++) s.d[i] = rv;
    return s;
  endfunction

  function automatic int mdl_count(input mdl_t s, input int dep);
    int c = 0;
    for (int i = 0; i < dep; i++) c += int'(s.v[i]);
    return c;
  endfunction

  function automatic logic mdl_ready(input mdl_t s, input int dep, input logic rstn,
                                     input logic fl, input logic orr);
    return rstn && !fl && (mdl_count(s, dep) < dep || orr);
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input int dep, input logic [7:0] rv,
                                    input logic fl, input logic iv, input logic [7:0] id,
                                    input logic orr);
    logic acc;
    if (fl) return mdl_clear(rv);
    acc = iv && mdl_ready(s, dep, 1'b1, 1'b0, orr);
    if (s.v[dep-1] && orr) s.v[dep-1] = 1'b0;
    for (int i = dep - 2; i >= 0; i--) begin
      if (!s.v[i+1] && s.v[i]) begin
        s.v[i+1] = 1'b1;
        s.d[i+1] = s.d[i];
        s.v[i]   = 1'b0;
      end
    end
    if (acc) begin
      s.v[0] = 1'b1;
      s.d[0] = id;
    end
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_a = mdl_clear(RVA);
      m_b = mdl_clear(RVB);
      exp_q_a.delete();
      exp_q_b.delete();
    end
    chk("a_in_ready", int'(in_ready_a), int'(mdl_ready(m_a, DA, rst_n, flush_a, out_ready_a)));
    chk("a_out_valid", int'(out_valid_a), int'(m_a.v[DA-1]));
    chk("a_out_data", int'(out_data_a), int'(m_a.d[DA-1]));
    chk("a_count", int'(count_a), mdl_count(m_a, DA));
    chk("b_in_ready", int'(in_ready_b), int'(mdl_ready(m_b, DB, rst_n, flush_b, out_ready_b)));
    chk("b_out_valid", int'(out_valid_b), int'(m_b.v[DB-1]));
    chk("b_out_data", int'(out_data_b), int'(m_b.d[DB-1]));
    chk("b_count", int'(count_b), mdl_count(m_b, DB));
    if (rst_n) begin
      if (m_a.v[DA-1] && out_ready_a) begin
        if (exp_q_a.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL a_spurious: got %0h, expected no word", out_data_a);
        end else chk("a_order", int'(out_data_a), int'(exp_q_a.pop_front()));
        got_a.push_back(out_data_a);
      end
      if (m_b.v[DB-1] && out_ready_b) begin
        if (exp_q_b.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL b_spurious: got %0h, expected no word", out_data_b);
        end else chk("b_order", int'(out_data_b), int'(exp_q_b.pop_front()));
        got_b.push_back(out_data_b);
      end
      if (in_valid_a && mdl_ready(m_a, DA, 1'b1, flush_a, out_ready_a)) exp_q_a.push_back(in_data_a);
      if (in_valid_b && mdl_ready(m_b, DB, 1'b1, flush_b, out_ready_b)) exp_q_b.push_back(in_data_b);
      if (flush_a) exp_q_a.delete();
      if (flush_b) exp_q_b.delete();
      m_a = mdl_step(m_a, DA, RVA, flush_a, in_valid_a, in_data_a, out_ready_a);
      m_b = mdl_step(m_b, DB, RVB, flush_b, in_valid_b, in_data_b, out_ready_b);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_or_a) out_ready_a = 1'($urandom_range(0, 1));
  endtask

  task automatic push_a(input logic [7:0] data);
    int   waited = 0;
    logic taken  = 1'b0;
    in_valid_a = 1'b1;
    in_data_a  = data;
    while (!taken && waited < 50) begin
      @(negedge clk);
      taken = in_ready_a;
      tick();
      waited++;
    end
    if (!taken) begin
      n_checks++; n_err++;
      $display("FAIL push_timeout: got no handshake for %0h, expected one within 50 cycles", data);
    end
    in_valid_a = 1'b0;
  endtask

  initial begin
    int w;
    bp_exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    m_a = mdl_clear(RVA);
    m_b = mdl_clear(RVB);
    rst_n = 1'b1;
    flush_a = 0; in_valid_a = 0; in_data_a = 0; out_ready_a = 0;
    flush_b = 0; in_valid_b = 0; in_data_b = 0; out_ready_b = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_out_valid", int'(out_valid_a), 0);
    chk("rst_a_count", int'(count_a), 0);
    chk("rst_a_out_data", int'(out_data_a), 'h00);
    chk("rst_a_in_ready", int'(in_ready_a), 0);
    chk("rst_b_out_data", int'(out_data_b), 'hFF);
    chk("rst_b_in_ready", int'(in_ready_b), 0);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("rel_a_in_ready", int'(in_ready_a), 1);

    // Reset mid-operation with a full pipe.
    push_a(8'h0C); push_a(8'h0D); push_a(8'h0E);
    chk("full_count", int'(count_a), 3);
    chk("full_out_data", int'(out_data_a), 'h0C);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid_a), 0);
    chk("midrst_count", int'(count_a), 0);
    chk("midrst_out_data", int'(out_data_a), 'h00);
    tick();
    rst_n = 1'b1;
    #1 chk("midrst_rel_in_ready", int'(in_ready_a), 1);
    tick();

    // Streaming 01..0A: first output after three edges, then one word per cycle.
    out_ready_a = 1'b1;
    got_a.delete();
    for (int c = 0; c < 14; c++) begin
      if (c == 2) chk("stream_latency", int'(out_valid_a), 0);
      if (c >= 3 && c <= 12) begin
        chk("stream_valid", int'(out_valid_a), 1);
        chk("stream_data", int'(out_data_a), c - 2);
      end
      if (c >= 3 && c <= 10) chk("stream_count", int'(count_a), 3);
      in_valid_a = (c < 10);
      in_data_a  = 8'(c + 1);
      tick();
    end
    chk("stream_n", got_a.size(), 10);

    // Backpressure.
    out_ready_a = 1'b0;
    got_a.delete();
    push_a(8'hA1); push_a(8'hA2); push_a(8'hA3);
    in_valid_a = 1'b1;
    in_data_a  = 8'hA4;
    #1;
    chk("bp_in_ready", int'(in_ready_a), 0);
    chk("bp_count", int'(count_a), 3);
    chk("bp_out_data", int'(out_data_a), 'hA1);
    tick(); tick();
    chk("bp_hold_data", int'(out_data_a), 'hA1);
    chk("bp_hold_valid", int'(out_valid_a), 1);
    out_ready_a = 1'b1;
    push_a(8'hA4);
    repeat (5) tick();
    chk("bp_n", got_a.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_seq", (i < got_a.size()) ? int'(got_a[i]) : 'h100, int'(bp_exp[i]));

    // Bubbles with random backpressure.
    got_a.delete();
    rnd_or_a = 1'b1;
    push_a(8'h11);
    tick(); tick();
    push_a(8'h22);
    w = 0;
    while (got_a.size() < 2 && w < 60) begin
      tick();
      w++;
    end
    rnd_or_a = 1'b0;
    out_ready_a = 1'b1;
    repeat (5) tick();
    chk("bubble_n", got_a.size(), 2);
    chk("bubble_w0", (got_a.size() > 0) ? int'(got_a[0]) : 'h100, 'h11);
    chk("bubble_w1", (got_a.size() > 1) ? int'(got_a[1]) : 'h100, 'h22);

    // Flush with two words held and 55 offered.
    got_a.delete();
    out_ready_a = 1'b0;
    push_a(8'h61); push_a(8'h62);
    chk("flush_pre_count", int'(count_a), 2);
    in_valid_a = 1'b1;
    in_data_a  = 8'h55;
    flush_a    = 1'b1;
    #1 chk("flush_in_ready", int'(in_ready_a), 0);
    tick();
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    chk("flush_count", int'(count_a), 0);
    chk("flush_out_valid", int'(out_valid_a), 0);
    chk("flush_out_data", int'(out_data_a), 'h00);
    out_ready_a = 1'b1;
    repeat (6) tick();
    chk("flush_nothing_out", got_a.size(), 0);

    // DEPTH=1: back-to-back 33, 44.
    out_ready_b = 1'b1;
    in_valid_b  = 1'b1;
    in_data_b   = 8'h33;
    tick();
    chk("b_first_valid", int'(out_valid_b), 1);
    chk("b_first_data", int'(out_data_b), 'h33);
    in_data_b = 8'h44;
    tick();
    chk("b_second_data", int'(out_data_b), 'h44);
    in_valid_b = 1'b0;
    tick();
    chk("b_drained_valid", int'(out_valid_b), 0);
    chk("b_drained_data", int'(out_data_b), 'h44);

    // Random traffic on both instances.
    for (int k = 0; k < 1500; k++) begin
      in_valid_a  = 1'($urandom_range(0, 1));
      in_data_a   = 8'($urandom);
      out_ready_a = ($urandom_range(0, 3) != 0);
      flush_a     = ($urandom_range(0, 29) == 0);
      in_valid_b  = 1'($urandom_range(0, 1));
      in_data_b   = 8'($urandom);
      out_ready_b = ($urandom_range(0, 2) != 0);
      flush_b     = ($urandom_range(0, 29) == 0);
      tick();
    end
    in_valid_a = 0; flush_a = 0; out_ready_a = 1;
    in_valid_b = 0; flush_b = 0; out_ready_b = 1;
    repeat (6) tick();
    chk("drain_a_count", int'(count_a), 0);
    chk("drain_b_count", int'(count_b), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
